// File: rtl/mem_pkg.sv
// mem_pkg: memory-side geometry shared across the memory subsystem.
//   ADDR_W     - block address width
//   BLOCK_BITS - width of one data block
package mem_pkg;

  localparam int ADDR_W     = 16;
  localparam int BLOCK_BITS = 32;

endpackage : mem_pkg

// File: rtl/switch_pkg.sv
// switch_pkg: shared types for the port switching / arbitration blocks.
//   arb_mode_e - arbitration policy selector
//     ARB_TDM : fixed rotating slot, one port per cycle, not work-conserving
//     ARB_RR  : work-conserving round-robin starting after the last winner
package switch_pkg;

  typedef enum logic {
    ARB_TDM = 1'b0,
    ARB_RR  = 1'b1
  } arb_mode_e;

endpackage : switch_pkg

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of requester-side and memory-side signals of
// mem_port_arbiter. Signal suffixes are relative to the arbiter.
//   slave  modport : the arbiter itself
//   master modport : the environment (requesters + memory)
// Requester side : req_i, we_i, addr_i, wdata_i -> gnt_o, rvalid_o, rdata_o
// Memory side    : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
//                  mem_rvalid_i, mem_rdata_i
// Status         : outstanding_o, err_o
interface mem_port_arbiter_if #(
  parameter int N          = 4,
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS,
  parameter int MAX_OUT    = 4
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [N-1:0]                 req_i;
  logic [N-1:0]                 we_i;
  logic [N-1:0][ADDR_W-1:0]     addr_i;
  logic [N-1:0][BLOCK_BITS-1:0] wdata_i;
  logic [N-1:0]                 gnt_o;

  logic                         mem_req_o;
  logic                         mem_we_o;
  logic [ADDR_W-1:0]            mem_addr_o;
  logic [BLOCK_BITS-1:0]        mem_wdata_o;
  logic                         mem_rvalid_i;
  logic [BLOCK_BITS-1:0]        mem_rdata_i;

  logic [N-1:0]                 rvalid_o;
  logic [BLOCK_BITS-1:0]        rdata_o;
  logic [CNT_W-1:0]             outstanding_o;
  logic                         err_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_rvalid_i, mem_rdata_i,
    output gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           rvalid_o, rdata_o, outstanding_o, err_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_rvalid_i, mem_rdata_i,
    input  gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           rvalid_o, rdata_o, outstanding_o, err_o
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_id_fifo.sv
// port_id_fifo: in-order FIFO holding the port ID of every outstanding read.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (clears pointers/count)
//   push_i       - write push_data_i at the tail (ignored when full)
//   push_data_i  - ID to store
//   pop_i        - drop the head entry (ignored when empty)
//   head_o       - current head entry (valid when !empty_o)
//   full_o       - DEPTH entries stored
//   empty_o      - no entries stored
//   count_o      - number of stored entries, 0..DEPTH
// Pointers wrap explicitly at DEPTH-1, so DEPTH=1 works as well.
module port_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never read before it is written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule : port_id_fifo

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between N requesters.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.slave: per-port req/we/addr/wdata in,
//           one-hot gnt_o out; memory strobe/we/addr/wdata out, read
//           response in; one-hot rvalid_o + broadcast rdata_o out;
//           outstanding_o (reads in flight) and sticky err_o out.
// The grant and the memory command are combinational from the winning
// port's inputs. Reads record their port ID in an in-order FIFO so that
// responses (in issue order, any latency) are routed back with no added
// latency. A read is only eligible while fewer than MAX_OUT reads are in
// flight; writes are never held back. N and MAX_OUT must be powers of 2.
module mem_port_arbiter
  import switch_pkg::*;
#(
  parameter int        N          = 4,
  parameter int        ADDR_W     = mem_pkg::ADDR_W,
  parameter int        BLOCK_BITS = mem_pkg::BLOCK_BITS,
  parameter int        MAX_OUT    = 4,
  parameter arb_mode_e MODE       = ARB_RR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      slot_q, slot_d;
  logic                  err_q, err_d;

  logic [N-1:0]          elig;
  logic                  gvld;
  logic [IDX_W-1:0]      gidx;
  logic [IDX_W-1:0]      idx;
  logic [ADDR_W-1:0]     addr_sel;
  logic [BLOCK_BITS-1:0] wdata_sel;

  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  logic [IDX_W-1:0]      head_id;
  logic [CNT_W-1:0]      fifo_count;

  // Eligibility looks at the registered count only: a response popping in
  // this cycle does not free a slot for a read until the next cycle.
  assign elig = bus.req_i & (bus.we_i | {N{~fifo_full}});

  always_comb begin
    gvld = 1'b0;
    gidx = '0;
    idx  = '0;
    if (MODE == ARB_RR) begin
      // Walk from the far end so the port closest to ptr wins last.
      for (int k = N - 1; k >= 0; k--) begin
        idx = ptr_q + IDX_W'(k);
        if (elig[idx]) begin
          gvld = 1'b1;
          gidx = idx;
        end
      end
    end else begin
      if (elig[slot_q]) begin
        gvld = 1'b1;
        gidx = slot_q;
      end
    end
    // Requests are combinational inputs; keep all strobes low in reset.
    gvld = gvld & rst_n;
  end

  assign addr_sel  = bus.addr_i[gidx];
  assign wdata_sel = bus.wdata_i[gidx];

  assign bus.gnt_o       = gvld ? (N'(1) << gidx) : '0;
  assign bus.mem_req_o   = gvld;
  assign bus.mem_we_o    = gvld & bus.we_i[gidx];
  assign bus.mem_addr_o  = gvld ? addr_sel  : '0;
  assign bus.mem_wdata_o = gvld ? wdata_sel : '0;

  assign push = gvld & ~bus.we_i[gidx];
  assign pop  = bus.mem_rvalid_i & ~fifo_empty;

  assign bus.rvalid_o      = pop ? (N'(1) << head_id) : '0;
  assign bus.rdata_o       = bus.mem_rdata_i;
  assign bus.outstanding_o = fifo_count;
  assign bus.err_o         = err_q;

  always_comb begin
    ptr_d  = gvld ? gidx + IDX_W'(1) : ptr_q;
    slot_d = slot_q + IDX_W'(1);
    err_d  = err_q | (bus.mem_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      slot_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      slot_q <= slot_d;
      err_q  <= err_d;
    end
  end

  port_id_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (gidx),
    .pop_i       (pop),
    .head_o      (head_id),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one round-robin and one TDM instance
// (N=4, MAX_OUT=2) driven by per-port traffic generators and an in-order
// memory with programmable latency, checked every cycle against a
// queue-based model of the arbitration rules plus directed expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import switch_pkg::*;

  localparam int N  = 4;
  localparam int AW = mem_pkg::ADDR_W;
  localparam int BB = mem_pkg::BLOCK_BITS;
  localparam int MO = 2;
  localparam int CW = $clog2(MO + 1);
  localparam int ND = 2;  // 0 = round-robin instance, 1 = TDM instance

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N(N), .ADDR_W(AW), .BLOCK_BITS(BB), .MAX_OUT(MO)) bus_rr ();
  mem_port_arbiter_if #(.N(N), .ADDR_W(AW), .BLOCK_BITS(BB), .MAX_OUT(MO)) bus_tdm ();

  mem_port_arbiter #(.N(N), .ADDR_W(AW), .BLOCK_BITS(BB), .MAX_OUT(MO), .MODE(ARB_RR))
    u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
  mem_port_arbiter #(.N(N), .ADDR_W(AW), .BLOCK_BITS(BB), .MAX_OUT(MO), .MODE(ARB_TDM))
    u_tdm (.clk(clk), .rst_n(rst_n), .bus(bus_tdm));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  string nm [ND] = '{"rr", "tdm"};

  // requesters
  int            rem_rd    [ND][N];
  int            rem_wr    [ND][N];
  bit            cur_v     [ND][N];
  bit            cur_we    [ND][N];
  logic [AW-1:0] cur_addr  [ND][N];
  logic [BB-1:0] cur_wdata [ND][N];
  // memory
  int            due       [ND][64];
  int            ndue      [ND];
  int            last_due  [ND];
  int            lat_fixed [ND];
  bit            force_rv  [ND];
  bit            rv        [ND];
  logic [BB-1:0] rdat      [ND];
  // reference model
  int            m_ptr     [ND];
  int            m_slot    [ND];
  int            m_ids     [ND][16];
  int            m_cnt     [ND];
  bit            m_err     [ND];
  // sampled outputs of the current cycle
  logic [N-1:0]  o_gnt     [ND];
  logic [N-1:0]  o_rvalid  [ND];
  logic          o_req     [ND];
  logic          o_we      [ND];
  logic [AW-1:0] o_addr    [ND];
  logic [BB-1:0] o_wdata   [ND];
  logic [BB-1:0] o_rdata   [ND];
  logic [CW-1:0] o_out     [ND];
  logic          o_err     [ND];

  // directed expectations
  int rot[5]       = '{0, 1, 2, 3, 0};
  int e42_gnt[14]  = '{1, 2, 8, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0};
  int e42_rv[14]   = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2, 0};
  int e42_out[14]  = '{0, 1, 2, 2, 2, 2, 1, 1, 2, 2, 2, 2, 1, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus_rr.req_i[i]    = cur_v[0][i];
      bus_rr.we_i[i]     = cur_we[0][i];
      bus_rr.addr_i[i]   = cur_addr[0][i];
      bus_rr.wdata_i[i]  = cur_wdata[0][i];
      bus_tdm.req_i[i]   = cur_v[1][i];
      bus_tdm.we_i[i]    = cur_we[1][i];
      bus_tdm.addr_i[i]  = cur_addr[1][i];
      bus_tdm.wdata_i[i] = cur_wdata[1][i];
    end
    bus_rr.mem_rvalid_i  = rv[0];
    bus_rr.mem_rdata_i   = rdat[0];
    bus_tdm.mem_rvalid_i = rv[1];
    bus_tdm.mem_rdata_i  = rdat[1];
  endtask

  task automatic sample();
    o_gnt[0] = bus_rr.gnt_o;        o_gnt[1] = bus_tdm.gnt_o;
    o_rvalid[0] = bus_rr.rvalid_o;  o_rvalid[1] = bus_tdm.rvalid_o;
    o_req[0] = bus_rr.mem_req_o;    o_req[1] = bus_tdm.mem_req_o;
    o_we[0] = bus_rr.mem_we_o;      o_we[1] = bus_tdm.mem_we_o;
    o_addr[0] = bus_rr.mem_addr_o;  o_addr[1] = bus_tdm.mem_addr_o;
    o_wdata[0] = bus_rr.mem_wdata_o; o_wdata[1] = bus_tdm.mem_wdata_o;
    o_rdata[0] = bus_rr.rdata_o;    o_rdata[1] = bus_tdm.rdata_o;
    o_out[0] = bus_rr.outstanding_o; o_out[1] = bus_tdm.outstanding_o;
    o_err[0] = bus_rr.err_o;        o_err[1] = bus_tdm.err_o;
  endtask

  // One clock cycle: called and returning at a falling edge.
  task automatic cycle();
    int g [ND];
    bit pop [ND];
    int t;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < N; i++) begin
        if (!cur_v[d][i] && (rem_rd[d][i] > 0 || rem_wr[d][i] > 0)) begin
          if (rem_rd[d][i] == 0)      cur_we[d][i] = 1'b1;
          else if (rem_wr[d][i] == 0) cur_we[d][i] = 1'b0;
          else                        cur_we[d][i] = ($urandom_range(0, 1) == 1);
          cur_v[d][i]     = 1'b1;
          cur_addr[d][i]  = AW'($urandom);
          cur_wdata[d][i] = BB'($urandom);
        end
      end
      rv[d]   = force_rv[d] || (ndue[d] > 0 && due[d][0] == cyc);
      rdat[d] = BB'($urandom);
    end
    apply();
    #1;
    sample();
    for (int d = 0; d < ND; d++) begin
      g[d] = -1;
      if (d == 0) begin
        for (int k = 0; k < N; k++) begin
          int p;
          p = (m_ptr[d] + k) % N;
          if (g[d] < 0 && cur_v[d][p] && (cur_we[d][p] || m_cnt[d] < MO)) g[d] = p;
        end
      end else begin
        if (cur_v[d][m_slot[d]] && (cur_we[d][m_slot[d]] || m_cnt[d] < MO)) g[d] = m_slot[d];
      end
      pop[d] = rv[d] && (m_cnt[d] > 0);
      chk({nm[d], "_gnt"}, 64'(o_gnt[d]), (g[d] >= 0) ? (64'd1 << g[d]) : 64'd0);
      chk({nm[d], "_mem_req"}, 64'(o_req[d]), 64'(g[d] >= 0));
      if (g[d] >= 0) begin
        chk({nm[d], "_mem_we"}, 64'(o_we[d]), 64'(cur_we[d][g[d]]));
        chk({nm[d], "_mem_addr"}, 64'(o_addr[d]), 64'(cur_addr[d][g[d]]));
        chk({nm[d], "_mem_wdata"}, 64'(o_wdata[d]), 64'(cur_wdata[d][g[d]]));
      end
      chk({nm[d], "_rvalid"}, 64'(o_rvalid[d]), pop[d] ? (64'd1 << m_ids[d][0]) : 64'd0);
      if (pop[d]) chk({nm[d], "_rdata"}, 64'(o_rdata[d]), 64'(rdat[d]));
      chk({nm[d], "_outstanding"}, 64'(o_out[d]), 64'(m_cnt[d]));
      chk({nm[d], "_err"}, 64'(o_err[d]), 64'(m_err[d]));
    end
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      if (pop[d]) begin
        for (int j = 0; j < 15; j++) m_ids[d][j] = m_ids[d][j+1];
        m_cnt[d]--;
      end else if (rv[d]) begin
        m_err[d] = 1'b1;
      end
      if (ndue[d] > 0 && due[d][0] == cyc) begin
        for (int j = 0; j < 63; j++) due[d][j] = due[d][j+1];
        ndue[d]--;
      end
      if (g[d] >= 0) begin
        if (!cur_we[d][g[d]]) begin
          m_ids[d][m_cnt[d]] = g[d];
          m_cnt[d]++;
          rem_rd[d][g[d]]--;
          t = cyc + ((lat_fixed[d] > 0) ? lat_fixed[d] : int'($urandom_range(1, 8)));
          if (t <= last_due[d]) t = last_due[d] + 1;
          due[d][ndue[d]] = t;
          ndue[d]++;
          last_due[d] = t;
        end else begin
          rem_wr[d][g[d]]--;
        end
        cur_v[d][g[d]] = 1'b0;
        m_ptr[d] = (g[d] + 1) % N;
      end
      m_slot[d] = (m_slot[d] + 1) % N;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset for two edges with every input active, checks that
  // nothing is driven, then clears bench state. Called at a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    bus_rr.req_i  = '1; bus_rr.we_i  = '0; bus_rr.mem_rvalid_i  = 1'b1;
    bus_tdm.req_i = '1; bus_tdm.we_i = '0; bus_tdm.mem_rvalid_i = 1'b1;
    #1;
    sample();
    for (int d = 0; d < ND; d++) begin
      chk({nm[d], "_rst_gnt"}, 64'(o_gnt[d]), 64'd0);
      chk({nm[d], "_rst_mem_req"}, 64'(o_req[d]), 64'd0);
      chk({nm[d], "_rst_rvalid"}, 64'(o_rvalid[d]), 64'd0);
      chk({nm[d], "_rst_outstanding"}, 64'(o_out[d]), 64'd0);
      chk({nm[d], "_rst_err"}, 64'(o_err[d]), 64'd0);
      for (int i = 0; i < N; i++) begin
        rem_rd[d][i] = 0;
        rem_wr[d][i] = 0;
        cur_v[d][i]  = 1'b0;
        cur_we[d][i] = 1'b0;
      end
      ndue[d] = 0; last_due[d] = -1; lat_fixed[d] = 0; force_rv[d] = 1'b0;
      m_ptr[d] = 0; m_slot[d] = 0; m_cnt[d] = 0; m_err[d] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit drained;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      rv[d] = 1'b0; rdat[d] = '0;
      for (int i = 0; i < N; i++) begin
        cur_addr[d][i] = '0; cur_wdata[d][i] = '0;
      end
    end
    @(negedge clk);

    // Round-robin rotation with every port writing.
    do_reset();
    for (int i = 0; i < N; i++) rem_wr[0][i] = 5;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_rotation", 64'(o_gnt[0]), 64'd1 << rot[k]);
      chk("rr_addr_track", 64'(o_addr[0]), 64'(cur_addr[0][rot[k]]));
    end

    // Ports 1 and 3 alternating without gaps; TDM serves port 2 every 4th cycle.
    do_reset();
    rem_wr[0][1] = 8; rem_wr[0][3] = 8;
    rem_wr[1][2] = 100;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_ports_1_3", 64'(o_gnt[0]), (k % 2 == 0) ? 64'd2 : 64'd8);
      chk("tdm_port_2", 64'(o_gnt[1]), (k % 4 == 2) ? 64'd4 : 64'd0);
    end

    // Read limit: two reads each from ports 0 and 1, one write from port 3,
    // fixed memory latency of 5.
    do_reset();
    lat_fixed[0] = 5;
    rem_rd[0][0] = 2; rem_rd[0][1] = 2; rem_wr[0][3] = 1;
    for (int k = 0; k < 14; k++) begin
      cycle();
      chk("lim_gnt", 64'(o_gnt[0]), 64'(e42_gnt[k]));
      chk("lim_rvalid", 64'(o_rvalid[0]), 64'(e42_rv[k]));
      chk("lim_outstanding", 64'(o_out[0]), 64'(e42_out[k]));
    end

    // Random traffic on both instances.
    do_reset();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < N; i++) begin
        rem_rd[d][i] = $urandom_range(0, 12);
        rem_wr[d][i] = $urandom_range(0, 12);
      end
    for (int k = 0; k < 300; k++) cycle();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < N; i++) begin
        rem_rd[d][i] = 0;
        rem_wr[d][i] = 0;
      end
    drained = 1'b0;
    for (int k = 0; k < 300 && !drained; k++) begin
      cycle();
      drained = 1'b1;
      for (int d = 0; d < ND; d++) begin
        if (ndue[d] != 0) drained = 1'b0;
        for (int i = 0; i < N; i++) if (cur_v[d][i]) drained = 1'b0;
      end
    end
    chk("drain_done", 64'(drained), 64'd1);

    // Response with nothing outstanding: no rvalid, sticky error until reset.
    force_rv[0] = 1'b1; force_rv[1] = 1'b1;
    cycle();
    chk("rr_spurious_rvalid", 64'(o_rvalid[0]), 64'd0);
    chk("tdm_spurious_rvalid", 64'(o_rvalid[1]), 64'd0);
    force_rv[0] = 1'b0; force_rv[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rr_err_sticky", 64'(o_err[0]), 64'd1);
      chk("tdm_err_sticky", 64'(o_err[1]), 64'd1);
    end
    do_reset();
    cycle();
    chk("rr_err_cleared", 64'(o_err[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
